// File: rtl/arbitro_banco_registradores.sv
// Write-port arbiter for the register file: clears x1..x31 after reset, then
// grants CPU writeback and UART loader requests round-robin with a registered write port.
module arbitro_banco_registradores #(
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_cpu_req,
    input  logic [4:0]  i_cpu_addr,
    input  logic [31:0] i_cpu_data,
    output logic        o_cpu_gnt,
    input  logic        i_uart_req,
    input  logic [4:0]  i_uart_addr,
    input  logic [31:0] i_uart_data,
    output logic        o_uart_gnt,
    output logic        o_wr_en,
    output logic [4:0]  o_wr_addr,
    output logic [31:0] o_wr_data,
    output logic        o_pronto
);

    typedef enum logic {LIMPA, ATIVO} estado_t;

    localparam logic ULT_CPU  = 1'b0;
    localparam logic ULT_UART = 1'b1;

    estado_t     r_estado;
    estado_t     w_estado_prox;
    logic [4:0]  r_contador;
    logic [4:0]  w_contador_prox;
    logic        r_ultimo;
    logic        w_ultimo_prox;
    logic        r_wr_en;
    logic        w_wr_en_prox;
    logic [4:0]  r_wr_addr;
    logic [4:0]  w_wr_addr_prox;
    logic [31:0] r_wr_data;
    logic [31:0] w_wr_data_prox;
    logic        r_pronto;
    logic        w_pronto_prox;
    logic        w_arbitra;
    logic        w_cpu_gnt;
    logic        w_uart_gnt;

    // Grants are also masked by reset so a handshake never completes on an aborting edge.
    assign w_arbitra  = r_pronto && !i_reset;
    assign w_cpu_gnt  = w_arbitra && i_cpu_req && (!i_uart_req || r_ultimo == ULT_UART);
    assign w_uart_gnt = w_arbitra && i_uart_req && (!i_cpu_req || r_ultimo == ULT_CPU);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_estado   <= (INIT_ZERO != 1'b0) ? LIMPA : ATIVO;
            r_contador <= 5'd1;
            r_ultimo   <= ULT_UART;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_pronto   <= 1'b0;
        end else begin
            r_estado   <= w_estado_prox;
            r_contador <= w_contador_prox;
            r_ultimo   <= w_ultimo_prox;
            r_wr_en    <= w_wr_en_prox;
            r_wr_addr  <= w_wr_addr_prox;
            r_wr_data  <= w_wr_data_prox;
            r_pronto   <= w_pronto_prox;
        end
    end

    always_comb begin
        w_estado_prox   = r_estado;
        w_contador_prox = r_contador;
        w_ultimo_prox   = r_ultimo;
        w_wr_en_prox    = 1'b0;
        w_wr_addr_prox  = r_wr_addr;
        w_wr_data_prox  = r_wr_data;
        w_pronto_prox   = r_pronto;
        case (r_estado)
            LIMPA: begin
                w_wr_en_prox   = 1'b1;
                w_wr_addr_prox = r_contador;
                w_wr_data_prox = '0;
                // Counter parks at 31 instead of wrapping; the state change ends the sweep.
                if (r_contador == 5'd31) begin
                    w_estado_prox = ATIVO;
                    w_pronto_prox = 1'b1;
                end else begin
                    w_contador_prox = r_contador + 5'd1;
                end
            end
            ATIVO: begin
                w_pronto_prox = 1'b1;
                if (w_cpu_gnt) begin
                    w_ultimo_prox = ULT_CPU;
                    if (i_cpu_addr != 5'd0) begin
                        w_wr_en_prox   = 1'b1;
                        w_wr_addr_prox = i_cpu_addr;
                        w_wr_data_prox = i_cpu_data;
                    end
                end else if (w_uart_gnt) begin
                    w_ultimo_prox = ULT_UART;
                    if (i_uart_addr != 5'd0) begin
                        w_wr_en_prox   = 1'b1;
                        w_wr_addr_prox = i_uart_addr;
                        w_wr_data_prox = i_uart_data;
                    end
                end
            end
            default: w_estado_prox = LIMPA;
        endcase
    end

    assign o_cpu_gnt  = w_cpu_gnt;
    assign o_uart_gnt = w_uart_gnt;
    assign o_wr_en    = r_wr_en;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;
    assign o_pronto   = r_pronto;

endmodule

// File: tb/tb_arbitro_banco_registradores.sv
// Directed bench for the register-file write arbiter: clear sweep, single/tied
// requests, x0 writes and reset abort, with hand-computed expectations.
module tb_arbitro_banco_registradores;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [4:0]  cpu_addr;
    logic [31:0] cpu_data;
    logic        cpu_gnt;
    logic        uart_req;
    logic [4:0]  uart_addr;
    logic [31:0] uart_data;
    logic        uart_gnt;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        pronto;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    arbitro_banco_registradores #(.INIT_ZERO(1'b1)) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_cpu_req   (cpu_req),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_data  (cpu_data),
        .o_cpu_gnt   (cpu_gnt),
        .i_uart_req  (uart_req),
        .i_uart_addr (uart_addr),
        .i_uart_data (uart_data),
        .o_uart_gnt  (uart_gnt),
        .o_wr_en     (wr_en),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .o_pronto    (pronto)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Registered outputs are sampled 2 time units after the edge; gnt is sampled
    // 1 unit after inputs change, both well clear of the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        cpu_req = 1'b0;  cpu_addr = '0;  cpu_data = '0;
        uart_req = 1'b0; uart_addr = '0; uart_data = '0;

        tick();
        tick();
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_pronto", {31'd0, pronto}, 32'd0);

        // CPU request held from reset release must wait out the whole sweep
        rst = 1'b0;
        cpu_req = 1'b1; cpu_addr = 5'd5; cpu_data = 32'hDEADBEEF;
        #1;
        check("pre_clear_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
        for (int i = 1; i <= 31; i++) begin
            tick();
            check($sformatf("clr%0d_wr_en", i), {31'd0, wr_en}, 32'd1);
            check($sformatf("clr%0d_wr_addr", i), {27'd0, wr_addr}, i);
            check($sformatf("clr%0d_wr_data", i), wr_data, 32'd0);
            check($sformatf("clr%0d_pronto", i), {31'd0, pronto}, (i == 31) ? 32'd1 : 32'd0);
            check($sformatf("clr%0d_cpu_gnt", i), {31'd0, cpu_gnt}, (i == 31) ? 32'd1 : 32'd0);
        end

        tick();
        cpu_req = 1'b0;
        check("cpu_wr_en", {31'd0, wr_en}, 32'd1);
        check("cpu_wr_addr", {27'd0, wr_addr}, 32'd5);
        check("cpu_wr_data", wr_data, 32'hDEADBEEF);
        #1;
        check("idle_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
        check("idle_uart_gnt", {31'd0, uart_gnt}, 32'd0);

        tick();
        check("idle_wr_en", {31'd0, wr_en}, 32'd0);
        check("idle_hold_addr", {27'd0, wr_addr}, 32'd5);
        check("idle_hold_data", wr_data, 32'hDEADBEEF);

        // UART write to x0: handshake completes, no write launched, UART becomes last winner
        uart_req = 1'b1; uart_addr = 5'd0; uart_data = 32'h00001234;
        #1;
        check("x0_uart_gnt", {31'd0, uart_gnt}, 32'd1);
        check("x0_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
        tick();
        uart_req = 1'b0;
        check("x0_wr_en", {31'd0, wr_en}, 32'd0);
        check("x0_hold_addr", {27'd0, wr_addr}, 32'd5);

        // Tie for 4 cycles: CPU first after the UART win, then strict alternation
        cpu_req = 1'b1;  cpu_addr = 5'd3;  cpu_data = 32'h33333333;
        uart_req = 1'b1; uart_addr = 5'd7; uart_data = 32'h77777777;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("tie%0d_cpu_gnt", k), {31'd0, cpu_gnt}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("tie%0d_uart_gnt", k), {31'd0, uart_gnt}, (k % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            check($sformatf("tie%0d_wr_en", k), {31'd0, wr_en}, 32'd1);
            check($sformatf("tie%0d_wr_addr", k), {27'd0, wr_addr}, (k % 2 == 0) ? 32'd3 : 32'd7);
            check($sformatf("tie%0d_wr_data", k), wr_data,
                  (k % 2 == 0) ? 32'h33333333 : 32'h77777777);
        end
        cpu_req = 1'b0; uart_req = 1'b0;
        tick();
        check("post_tie_wr_en", {31'd0, wr_en}, 32'd0);
        check("post_tie_hold_addr", {27'd0, wr_addr}, 32'd7);

        // Reset during the clear sweep at address 12 aborts and restarts at 1
        rst = 1'b1;
        tick();
        check("rst2_pronto", {31'd0, pronto}, 32'd0);
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) tick();
        check("abort_pre_addr", {27'd0, wr_addr}, 32'd12);
        check("abort_pre_wr_en", {31'd0, wr_en}, 32'd1);
        rst = 1'b1;
        tick();
        check("abort_wr_en", {31'd0, wr_en}, 32'd0);
        check("abort_wr_addr", {27'd0, wr_addr}, 32'd0);
        check("abort_pronto", {31'd0, pronto}, 32'd0);
        rst = 1'b0;
        tick();
        check("restart_wr_en", {31'd0, wr_en}, 32'd1);
        check("restart_wr_addr", {27'd0, wr_addr}, 32'd1);
        tick();
        check("restart2_wr_addr", {27'd0, wr_addr}, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
